// File: rtl/axis_arb_pkg.sv
// Shared types and the round-robin search used by the packet arbiters.
// rr_pick scans at most 8 requesters, starting at ptr and wrapping modulo n.
package axis_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam int MAX_IN = 8;

  function automatic logic [2:0] rr_pick(input logic [MAX_IN-1:0] valid,
                                         input logic [2:0]        ptr,
                                         input int                n);
    logic [2:0] pick;
    logic [2:0] j;
    logic       found;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_IN; k++) begin
      j = 3'((int'(ptr) + k) % n);
      if (k < n && !found && valid[j]) begin
        found = 1'b1;
        pick  = j;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_pkt_arbiter_if.sv
// Bundle of the NUM_IN input streams and the merged output stream.
// master = traffic side (sources + sink), slave = the arbiter.
interface axis_pkt_arbiter_if #(
  parameter int NUM_IN = 2,
  parameter int DATA_W = 64,
  parameter int USER_W = 64
);
  logic [NUM_IN*DATA_W-1:0]   in_axis_tdata;
  logic [NUM_IN*DATA_W/8-1:0] in_axis_tkeep;
  logic [NUM_IN*USER_W-1:0]   in_axis_tuser;
  logic [NUM_IN-1:0]          in_axis_tlast;
  logic [NUM_IN-1:0]          in_axis_tvalid;
  logic [NUM_IN-1:0]          in_axis_tready;
  logic [DATA_W-1:0]          out_axis_tdata;
  logic [DATA_W/8-1:0]        out_axis_tkeep;
  logic [USER_W-1:0]          out_axis_tuser;
  logic                       out_axis_tlast;
  logic                       out_axis_tvalid;
  logic                       out_axis_tready;

  modport master (
    output in_axis_tdata, in_axis_tkeep, in_axis_tuser, in_axis_tlast, in_axis_tvalid,
    input  in_axis_tready,
    input  out_axis_tdata, out_axis_tkeep, out_axis_tuser, out_axis_tlast, out_axis_tvalid,
    output out_axis_tready
  );

  modport slave (
    input  in_axis_tdata, in_axis_tkeep, in_axis_tuser, in_axis_tlast, in_axis_tvalid,
    output in_axis_tready,
    output out_axis_tdata, out_axis_tkeep, out_axis_tuser, out_axis_tlast, out_axis_tvalid,
    input  out_axis_tready
  );
endinterface

// File: rtl/rr_priority_sel.sv
// Combinational round-robin selector: first asserted req at or above ptr, wrapping.
// Zero latency; no handshake of its own.
module rr_priority_sel
  import axis_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  logic [MAX_IN-1:0] req_ext;
  logic [2:0]        pick;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
  end

  assign pick = rr_pick(req_ext, 3'(ptr), N);
  assign any  = |req;
  assign idx  = IW'(pick);

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin merge of NUM_IN AXI-Stream sources; one idle arbitration
// cycle per packet, then zero-latency pass-through. Optional counters under ARB_STATS_EN.
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_IN = 2,
  parameter int DATA_W = 64,
  parameter int USER_W = 64,
  parameter int IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic               apclk,
  input  logic               apresetn,
  axis_pkt_arbiter_if.slave  axis,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               busy
`ifdef ARB_STATS_EN
  ,
  output logic [NUM_IN*32-1:0] pkt_count,
  output logic [31:0]          stall_cycles
`endif
);

  localparam int KEEP_W = DATA_W / 8;

  arb_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] nxt_ptr;
  logic             win_any;
  logic             beat_acc;

  rr_priority_sel #(.N(NUM_IN), .IW(IDX_W)) u_sel (
    .req (axis.in_axis_tvalid),
    .ptr (rr_ptr),
    .any (win_any),
    .idx (win_idx)
  );

  // Outside XFER every output is parked at zero so nothing leaks during arbitration.
  always_comb begin
    axis.out_axis_tdata  = '0;
    axis.out_axis_tkeep  = '0;
    axis.out_axis_tuser  = '0;
    axis.out_axis_tlast  = 1'b0;
    axis.out_axis_tvalid = 1'b0;
    axis.in_axis_tready  = '0;
    if (state == XFER) begin
      axis.out_axis_tdata  = axis.in_axis_tdata[int'(grant_idx)*DATA_W +: DATA_W];
      axis.out_axis_tkeep  = axis.in_axis_tkeep[int'(grant_idx)*KEEP_W +: KEEP_W];
      axis.out_axis_tuser  = axis.in_axis_tuser[int'(grant_idx)*USER_W +: USER_W];
      axis.out_axis_tlast  = axis.in_axis_tlast[grant_idx];
      axis.out_axis_tvalid = axis.in_axis_tvalid[grant_idx];
      axis.in_axis_tready[grant_idx] = axis.out_axis_tready;
    end
  end

  assign beat_acc = (state == XFER) && axis.out_axis_tvalid && axis.out_axis_tready;
  assign nxt_ptr  = (grant_idx == IDX_W'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge apclk or negedge apresetn) begin
    if (!apresetn) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_any) begin
            grant_idx <= win_idx;
            state     <= XFER;
            busy      <= 1'b1;
          end
        end
        XFER: begin
          if (beat_acc && axis.out_axis_tlast) begin
            rr_ptr <= nxt_ptr;
            state  <= IDLE;
            busy   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_STATS_EN
  // Packet counters wrap; the stall counter saturates so long stalls stay visible.
  always_ff @(posedge apclk or negedge apresetn) begin
    if (!apresetn) begin
      pkt_count    <= '0;
      stall_cycles <= '0;
    end else begin
      if (beat_acc && axis.out_axis_tlast)
        pkt_count[int'(grant_idx)*32 +: 32] <= pkt_count[int'(grant_idx)*32 +: 32] + 32'd1;
      if (state == XFER && axis.out_axis_tvalid && !axis.out_axis_tready && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Randomised bench for axis_pkt_arbiter against a packet-order round-robin model.
module tb_axis_pkt_arbiter;
  localparam int NUM_IN = 2;
  localparam int DATA_W = 64;
  localparam int USER_W = 64;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic [63:0] user;
    logic        last;
    int          src;
  } beat_t;

  logic       apclk = 1'b0;
  logic       apresetn = 1'b0;
  logic [0:0] grant_idx;
  logic       busy;
`ifdef ARB_STATS_EN
  logic [NUM_IN*32-1:0] pkt_count;
  logic [31:0]          stall_cycles;
`endif

  axis_pkt_arbiter_if #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .USER_W(USER_W)) bus ();

  axis_pkt_arbiter #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .USER_W(USER_W)) dut (
    .apclk     (apclk),
    .apresetn  (apresetn),
    .axis      (bus),
    .grant_idx (grant_idx),
    .busy      (busy)
`ifdef ARB_STATS_EN
    ,
    .pkt_count    (pkt_count),
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 apclk = ~apclk;

  int    errors = 0;
  int    checks = 0;
  int    m_ptr = 0;
  int    glob_cyc = 0;
  int    exp_pkts[NUM_IN];
  int    tb_stall = 0;
  beat_t src_q[NUM_IN][$];
  int    plen_q[NUM_IN][$];
  beat_t exp_q[$];

  task automatic clear_inputs();
    bus.in_axis_tdata  = '0;
    bus.in_axis_tkeep  = '0;
    bus.in_axis_tuser  = '0;
    bus.in_axis_tlast  = '0;
    bus.in_axis_tvalid = '0;
  endtask

  task automatic add_pkt(input int s, input int len, input int fixed_keep);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {$urandom, $urandom};
      b.keep = (fixed_keep < 0) ? 8'($urandom) : 8'(fixed_keep);
      b.user = {$urandom, $urandom};
      b.last = (i == len - 1);
      b.src  = s;
      src_q[s].push_back(b);
    end
    plen_q[s].push_back(len);
  endtask

  // Whole-packet round-robin: every pending packet is already offered, so the
  // order is simply "next source with packets left, starting after the last winner".
  task automatic build_expected();
    int off[NUM_IN];
    int s;
    int len;
    logic any;
    for (int i = 0; i < NUM_IN; i++) off[i] = 0;
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      s = 0;
      for (int k = 0; k < NUM_IN; k++) begin
        if (!any && plen_q[(m_ptr + k) % NUM_IN].size() > 0) begin
          any = 1'b1;
          s = (m_ptr + k) % NUM_IN;
        end
      end
      if (any) begin
        len = plen_q[s].pop_front();
        for (int b = 0; b < len; b++) exp_q.push_back(src_q[s][off[s] + b]);
        off[s] += len;
        exp_pkts[s]++;
        m_ptr = (s + 1) % NUM_IN;
      end
    end
  endtask

  // mode 0: sink always ready, 1: 50 high / 10 low, 2: random.
  task automatic run_traffic(input int mode, input int gap_pct, output int cycles);
    beat_t e;
    beat_t h;
    logic  sop[NUM_IN];
    logic  prev_last;
    int    cyc;
    for (int i = 0; i < NUM_IN; i++) sop[i] = 1'b1;
    prev_last = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 5000) begin
      @(negedge apclk);
      for (int s = 0; s < NUM_IN; s++) begin
        if (src_q[s].size() > 0) begin
          h = src_q[s][0];
          bus.in_axis_tdata[s*64 +: 64] = h.data;
          bus.in_axis_tkeep[s*8 +: 8]   = h.keep;
          bus.in_axis_tuser[s*64 +: 64] = h.user;
          bus.in_axis_tlast[s]          = h.last;
          bus.in_axis_tvalid[s]         = sop[s] ? 1'b1 : ($urandom_range(99) >= gap_pct);
        end else begin
          bus.in_axis_tvalid[s] = 1'b0;
        end
      end
      case (mode)
        0:       bus.out_axis_tready = 1'b1;
        1:       bus.out_axis_tready = ((glob_cyc + 45) % 60) < 50;
        default: bus.out_axis_tready = 1'($urandom_range(1));
      endcase
      #1;
      checks++;
      if ((bus.in_axis_tready & ~(2'b01 << grant_idx)) != 0 || (!busy && bus.in_axis_tready != 0)) begin
        errors++;
        $display("FAIL ready_isolation: in_axis_tready=%b with grant=%0d busy=%0b", bus.in_axis_tready, grant_idx, busy);
      end
      if (prev_last) begin
        checks++;
        if (bus.out_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL arb_gap: tvalid=%0b busy=%0b in cycle after tlast, want 0 0", bus.out_axis_tvalid, busy);
        end
      end
      prev_last = 1'b0;
      if (bus.out_axis_tvalid && !bus.out_axis_tready) tb_stall++;
      if (bus.out_axis_tvalid && bus.out_axis_tready) begin
        e = exp_q.pop_front();
        checks++;
        if (grant_idx !== 1'(e.src) || bus.out_axis_tdata !== e.data || bus.out_axis_tkeep !== e.keep ||
            bus.out_axis_tuser !== e.user || bus.out_axis_tlast !== e.last) begin
          errors++;
          $display("FAIL beat: got src=%0d d=%h k=%h u=%h l=%0b want src=%0d d=%h k=%h u=%h l=%0b",
                   grant_idx, bus.out_axis_tdata, bus.out_axis_tkeep, bus.out_axis_tuser, bus.out_axis_tlast,
                   e.src, e.data, e.keep, e.user, e.last);
        end
        prev_last = bus.out_axis_tlast;
      end
      for (int s = 0; s < NUM_IN; s++) begin
        if (bus.in_axis_tvalid[s] && bus.in_axis_tready[s] && src_q[s].size() > 0) begin
          h = src_q[s].pop_front();
          sop[s] = h.last;
        end
      end
      cyc++;
      glob_cyc++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d beats still expected after %0d cycles, want 0", exp_q.size(), cyc);
      exp_q.delete();
    end
    @(negedge apclk);
    clear_inputs();
    for (int s = 0; s < NUM_IN; s++) src_q[s].delete();
    cycles = cyc;
`ifdef ARB_STATS_EN
    for (int s = 0; s < NUM_IN; s++) begin
      checks++;
      if (pkt_count[s*32 +: 32] !== 32'(exp_pkts[s])) begin
        errors++;
        $display("FAIL pkt_count[%0d]: got %0d want %0d", s, pkt_count[s*32 +: 32], exp_pkts[s]);
      end
    end
    checks++;
    if (stall_cycles !== 32'(tb_stall)) begin
      errors++;
      $display("FAIL stall_cycles: got %0d want %0d", stall_cycles, tb_stall);
    end
`endif
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.out_axis_tready = 1'b1;
    bus.in_axis_tvalid  = '1;
    apresetn = 1'b0;
    #200;
    @(negedge apclk);
    checks++;
    if (bus.out_axis_tvalid !== 1'b0 || bus.in_axis_tready !== '0 || grant_idx !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: tvalid=%0b tready=%b grant=%0d busy=%0b want 0 00 0 0",
               bus.out_axis_tvalid, bus.in_axis_tready, grant_idx, busy);
    end
    clear_inputs();
    apresetn = 1'b1;
    m_ptr = 0;
    for (int s = 0; s < NUM_IN; s++) exp_pkts[s] = 0;
    tb_stall = 0;
    repeat (3) @(negedge apclk);
    checks++;
    if (busy !== 1'b0 || bus.out_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%0b tvalid=%0b want 0 0", busy, bus.out_axis_tvalid);
    end
  endtask

  task automatic test_simultaneous();
    int cyc;
    add_pkt(0, 4, -1);
    add_pkt(1, 4, -1);
    build_expected();
    run_traffic(0, 0, cyc);
    checks++;
    if (cyc != 10) begin
      errors++;
      $display("FAIL simul_cycles: got %0d want 10", cyc);
    end
  endtask

  task automatic test_fairness();
    int cyc;
    add_pkt(0, 2, -1);
    build_expected();
    run_traffic(0, 0, cyc);
    add_pkt(0, 3, -1);
    add_pkt(0, 2, -1);
    add_pkt(1, 3, -1);
    build_expected();
    run_traffic(0, 0, cyc);
    checks++;
    if (cyc != 11) begin
      errors++;
      $display("FAIL fair_cycles: got %0d want 11", cyc);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    glob_cyc = 0;
    add_pkt(0, 20, -1);
    build_expected();
    run_traffic(1, 0, cyc);
    checks++;
    if (cyc != 31) begin
      errors++;
      $display("FAIL bp_cycles: got %0d want 31", cyc);
    end
  endtask

  task automatic test_single_beat();
    int cyc;
    for (int i = 0; i < 3; i++) begin
      add_pkt(0, 1, 'h0F);
      add_pkt(1, 1, 'h0F);
    end
    build_expected();
    run_traffic(0, 0, cyc);
    checks++;
    if (cyc != 12) begin
      errors++;
      $display("FAIL single_cycles: got %0d want 12", cyc);
    end
  endtask

  task automatic test_random();
    int cyc;
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < NUM_IN; s++)
        for (int p = 0; p < 3; p++) add_pkt(s, $urandom_range(1, 6), -1);
      build_expected();
      run_traffic(2, 30, cyc);
    end
  endtask

  task automatic test_reset_mid();
    int    acc;
    int    cyc;
    int    guard;
    beat_t h;
    add_pkt(0, 8, -1);
    plen_q[0].delete();
    acc = 0;
    guard = 0;
    bus.out_axis_tready = 1'b1;
    while (acc < 3 && guard < 100) begin
      @(negedge apclk);
      h = src_q[0][0];
      bus.in_axis_tdata[63:0] = h.data;
      bus.in_axis_tkeep[7:0]  = h.keep;
      bus.in_axis_tuser[63:0] = h.user;
      bus.in_axis_tlast[0]    = h.last;
      bus.in_axis_tvalid[0]   = 1'b1;
      #1;
      if (bus.out_axis_tvalid && bus.out_axis_tready) begin
        void'(src_q[0].pop_front());
        acc++;
      end
      guard++;
    end
    @(negedge apclk);
    apresetn = 1'b0;
    #1;
    checks++;
    if (bus.out_axis_tvalid !== 1'b0 || bus.in_axis_tready !== '0 || busy !== 1'b0 || grant_idx !== 1'b0) begin
      errors++;
      $display("FAIL midreset: tvalid=%0b tready=%b busy=%0b grant=%0d want 0 00 0 0",
               bus.out_axis_tvalid, bus.in_axis_tready, busy, grant_idx);
    end
`ifdef ARB_STATS_EN
    checks++;
    if (pkt_count !== '0 || stall_cycles !== '0) begin
      errors++;
      $display("FAIL midreset_stats: pkt_count=%h stall=%0d want 0 0", pkt_count, stall_cycles);
    end
`endif
    repeat (2) @(negedge apclk);
    clear_inputs();
    src_q[0].delete();
    apresetn = 1'b1;
    m_ptr = 0;
    for (int s = 0; s < NUM_IN; s++) exp_pkts[s] = 0;
    tb_stall = 0;
    add_pkt(1, 5, -1);
    build_expected();
    run_traffic(0, 0, cyc);
  endtask

  initial begin
    clear_inputs();
    bus.out_axis_tready = 1'b0;
    for (int s = 0; s < NUM_IN; s++) exp_pkts[s] = 0;
    test_reset();
    test_simultaneous();
    test_fairness();
    test_backpressure();
    test_single_beat();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_pkt_arbiter.md
Name: axis_pkt_arbiter

Overview:
Packet-granular round-robin arbiter that merges NUM_IN AXI-Stream sources onto one AXI-Stream sink. Example: header_handler toNet traffic plus a control/ARP generator sharing the single network TX port.
- Holds a grant for a whole packet (until the tlast beat is accepted) so packets never interleave.
- Pass-through datapath with no buffering; sits between the memcached header path and the MAC-side stream.

Parameters:
NUM_IN, 2, number of input streams (2..8)
DATA_W, 64, tdata width; tkeep width is DATA_W/8
USER_W, 64, tuser width

Ports:
apclk  in  1  clock
apresetn  in  1  asynchronous active-low reset
in_axis_tdata  in  NUM_IN*DATA_W  input i occupies bits [i*DATA_W +: DATA_W]
in_axis_tkeep  in  NUM_IN*DATA_W/8  per-input byte enables
in_axis_tuser  in  NUM_IN*USER_W  per-input sideband
in_axis_tlast  in  NUM_IN  per-input end of packet
in_axis_tvalid  in  NUM_IN  per-input valid
in_axis_tready  out  NUM_IN  per-input ready
out_axis_tdata  out  DATA_W  merged data
out_axis_tkeep  out  DATA_W/8  merged keep
out_axis_tuser  out  USER_W  merged sideband
out_axis_tlast  out  1  merged last
out_axis_tvalid  out  1  merged valid
out_axis_tready  in  1  sink ready
grant_idx  out  $clog2(NUM_IN)  currently/last granted input
busy  out  1  high while a packet is in flight

Behaviour:
- Reset: apclk and apresetn as already decided — one clock; reset is asynchronous and active-low.
  - State = IDLE, rr_ptr = 0, grant_idx = 0, busy = 0.
  - out_axis_tvalid = 0, in_axis_tready = 0; data outputs are don't-care but driven to 0.
- FSM states IDLE and XFER.
- IDLE:
  - Winner = first i with in_axis_tvalid[i], searched from rr_ptr upward modulo NUM_IN.
  - If any input is valid: register grant_idx = winner, go to XFER next cycle.
  - Arbitration costs exactly one cycle per packet; no beat is accepted in IDLE.
- XFER (combinational pass-through of the granted input g = grant_idx):
  - out_axis_* = in_axis_*[g]; out_axis_tvalid = in_axis_tvalid[g].
  - in_axis_tready[g] = out_axis_tready; all other in_axis_tready bits = 0.
  - Beat accepted when out_axis_tvalid && out_axis_tready.
  - Accepted beat with tlast = 1: go to IDLE, rr_ptr = g+1 mod NUM_IN.
- Zero latency through the datapath. Per packet the output sees 1 idle arbitration cycle, then beats at the sink rate.
- Granted source dropping tvalid mid-packet: grant is held and out_axis_tvalid follows it. No timeout.
- Single-beat packet (tlast on first beat): accepted normally, then return to IDLE.
- Valid rising on other inputs during XFER: ignored until IDLE.
- Sole active requester: it wins every arbitration (no starvation penalty).
- apresetn asserted mid-packet: immediate return to reset values. The partial packet is truncated; recovery of that packet is upstream's responsibility.
- busy = (state == XFER).
- No tkeep/tuser modification; tuser is passed verbatim.

Optional Feature:
ARB_STATS_EN
- Defined: adds output pkt_count (NUM_IN*32 bits). Per-input 32-bit counter, incremented on that input's accepted tlast beat, wraps 0xFFFFFFFF→0, cleared by reset.
- Also adds output stall_cycles (32 bits), incremented every XFER cycle with out_axis_tvalid && !out_axis_tready, saturating at 0xFFFFFFFF.
- Undefined: these ports and all their logic are absent.

Decomposition:
- Package axis_arb_pkg: arb_state_t enum {IDLE, XFER}, and a function rr_pick(valid, ptr) returning the index.
- Sub-module rr_priority_sel: combinational round-robin search.
- Keep it separate so it can be reused by other memcached arbiters.

Test Plan:
- Reset: apresetn low 200 ns → out_axis_tvalid = 0, in_axis_tready = 0, grant_idx = 0, busy = 0; release → stays IDLE with no valid inputs.
- Both inputs present 4-beat packets simultaneously, sink always ready → input 0 packet (4 beats), 1 idle cycle, input 1 packet; no interleave; grant_idx sequence 0,1.
- Input 0 back-to-back packets, input 1 one packet, rr_ptr = 1 → order in1, in0, in0; input 1 not starved.
- out_axis_tready toggles (50 cycles high, 10 low) during a 20-beat packet → every beat delivered once and in order; in_axis_tready[1] stays 0 throughout.
- Single-beat packets (tlast = 1, tkeep = 0x0F) alternating sources → each emitted with tkeep 0x0F, tuser unchanged, 2 cycles per packet.
- apresetn asserted at beat 3 of 8 → outputs reset within same cycle; after release a fresh packet from input 1 passes intact. With ARB_STATS_EN: counts reset to 0, then pkt_count[1] = 1.
